// File: rtl/title_value_bcd_scheduler.sv
// rtl/title_value_bcd_scheduler.sv - frame-triggered shared double-dabble BCD converter for three title values
module title_value_bcd_scheduler #(
  parameter int          VAL_W  = 24,
  parameter int          DIGITS = 8,
  parameter logic [10:0] X_TRIG = 11'd0,
  parameter logic [9:0]  Y_TRIG = 10'd480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           clk_x,
  input  logic [9:0]            clk_y,
  input  logic [VAL_W-1:0]      count_val,
  input  logic [VAL_W-1:0]      sr_mass_val,
  input  logic [VAL_W-1:0]      com_mass_val,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [4*DIGITS-1:0]   sr_mass_bcd,
  output logic [4*DIGITS-1:0]   com_mass_bcd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(VAL_W + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VAL_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_STORE,
    S_PUBLISH
  } state_t;

  state_t            state;
  logic [1:0]        sel;
  logic [ITER_W-1:0] iter;
  logic [VAL_W-1:0]  bin_sr;
  logic [BCD_W-1:0]  bcd_sr;
  logic [BCD_W-1:0]  bcd_adj;
  logic [VAL_W-1:0]  snap0, snap1, snap2;
  logic [VAL_W-1:0]  snap_sel;
  logic [BCD_W-1:0]  shadow0, shadow1, shadow2;
  logic              match, match_d, trig;

  // Trigger point detection; only the first cycle of a held match counts
  assign match = (clk_x == X_TRIG) && (clk_y == Y_TRIG);
  assign trig  = match && !match_d;

  // Remember last cycle's match so a held coordinate gives one trigger
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) match_d <= 1'b0;
    else        match_d <= match;
  end

  // Pick the snapshot currently being converted
  always_comb begin
    case (sel)
      2'd0:    snap_sel = snap0;
      2'd1:    snap_sel = snap1;
      default: snap_sel = snap2;
    endcase
  end

  // Double-dabble correction: nibbles of 5 or more get +3 before the shift
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  // Conversion sequencer: snapshot, three serial conversions, atomic publish
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      sel          <= 2'd0;
      iter         <= '0;
      bin_sr       <= '0;
      bcd_sr       <= '0;
      snap0        <= '0;
      snap1        <= '0;
      snap2        <= '0;
      shadow0      <= '0;
      shadow1      <= '0;
      shadow2      <= '0;
      count_bcd    <= '0;
      sr_mass_bcd  <= '0;
      com_mass_bcd <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig) begin
            snap0 <= count_val;
            snap1 <= sr_mass_val;
            snap2 <= com_mass_val;
            sel   <= 2'd0;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          bin_sr <= snap_sel;
          bcd_sr <= '0;
          iter   <= '0;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[VAL_W-1]};
          bin_sr <= {bin_sr[VAL_W-2:0], 1'b0};
          if (iter == ITER_LAST) begin
            state <= S_STORE;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        S_STORE: begin
          case (sel)
            2'd0:    shadow0 <= bcd_sr;
            2'd1:    shadow1 <= bcd_sr;
            default: shadow2 <= bcd_sr;
          endcase
          if (sel == 2'd2) begin
            state <= S_PUBLISH;
          end else begin
            sel   <= sel + 2'd1;
            state <= S_LOAD;
          end
        end
        S_PUBLISH: begin
          count_bcd    <= shadow0;
          sr_mass_bcd  <= shadow1;
          com_mass_bcd <= shadow2;
          frame_done   <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_title_value_bcd_scheduler.sv
// tb/tb_title_value_bcd_scheduler.sv - randomized model-checked bench for title_value_bcd_scheduler
module tb_title_value_bcd_scheduler;

  localparam int LAT = 3 * (24 + 2) + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] clk_x = 11'd100;
  logic [9:0]  clk_y = 10'd0;
  logic [23:0] count_val = '0, sr_mass_val = '0, com_mass_val = '0;
  logic [31:0] count_bcd, sr_mass_bcd, com_mass_bcd;
  logic        busy, frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  title_value_bcd_scheduler dut (
    .clk(clk), .reset(reset), .clk_x(clk_x), .clk_y(clk_y),
    .count_val(count_val), .sr_mass_val(sr_mass_val), .com_mass_val(com_mass_val),
    .count_bcd(count_bcd), .sr_mass_bcd(sr_mass_bcd), .com_mass_bcd(com_mass_bcd),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(input logic [23:0] v);
    int unsigned n;
    logic [31:0] r;
    n = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: trigger edge, snapshot, publish LAT edges later
  logic [23:0] m_snap0 = '0, m_snap1 = '0, m_snap2 = '0;
  logic [31:0] e_cnt = '0, e_sr = '0, e_com = '0;
  logic        e_fd = 1'b0, m_busy = 1'b0, m_match_d = 1'b0, m_match;
  int          m_cnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_cnt = '0; e_sr = '0; e_com = '0;
      e_fd = 1'b0; m_busy = 1'b0; m_match_d = 1'b0; m_cnt = 0;
      m_snap0 = '0; m_snap1 = '0; m_snap2 = '0;
    end else begin
      m_match = (clk_x == 11'd0) && (clk_y == 10'd480);
      e_fd = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == LAT) begin
          e_cnt = to_bcd(m_snap0);
          e_sr  = to_bcd(m_snap1);
          e_com = to_bcd(m_snap2);
          e_fd  = 1'b1;
          m_busy = 1'b0;
        end
      end else if (m_match && !m_match_d) begin
        m_snap0 = count_val; m_snap1 = sr_mass_val; m_snap2 = com_mass_val;
        m_busy = 1'b1;
        m_cnt = 0;
      end
      m_match_d = m_match;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("count_bcd", count_bcd, e_cnt);
    check("sr_mass_bcd", sr_mass_bcd, e_sr);
    check("com_mass_bcd", com_mass_bcd, e_com);
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
  end

  // One conversion window of 150 cycles with optional input change and retrigger
  task automatic run_conv(input int hold, input int chg_at, input logic [23:0] chg_val,
                          input int retrig_at, output int edges, output int pulses);
    int cyc;
    @(negedge clk);
    clk_x = 11'd0; clk_y = 10'd480;
    cyc = 0; edges = -1; pulses = 0;
    repeat (150) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) clk_x = 11'd5;
      if (cyc == chg_at) count_val = chg_val;
      if (cyc == retrig_at) clk_x = 11'd0;
      if (cyc == retrig_at + 1) clk_x = 11'd5;
      if (frame_done) begin
        pulses++;
        if (edges < 0) edges = cyc - 1;
      end
    end
  endtask

  int edges, pulses;

  initial begin
    check("model_bcd_12345", to_bcd(24'd12345), 32'h00012345);
    check("model_bcd_max", to_bcd(24'hFFFFFF), 32'h16777215);

    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_count", count_bcd, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    count_val = 24'd12345; sr_mass_val = 24'd678; com_mass_val = 24'd0;
    run_conv(1, -1, '0, -10, edges, pulses);
    check("t2_latency", edges, LAT);
    check("t2_pulses", pulses, 1);
    check("t2_count", count_bcd, 32'h00012345);
    check("t2_sr", sr_mass_bcd, 32'h00000678);
    check("t2_com", com_mass_bcd, 32'h0);

    count_val = 24'hFFFFFF; sr_mass_val = 24'hFFFFFF; com_mass_val = 24'hFFFFFF;
    run_conv(1, -1, '0, -10, edges, pulses);
    check("t3_max_count", count_bcd, 32'h16777215);
    check("t3_max_com", com_mass_bcd, 32'h16777215);
    count_val = 0; sr_mass_val = 0; com_mass_val = 0;
    run_conv(1, -1, '0, -10, edges, pulses);
    check("t3_zero_sr", sr_mass_bcd, 32'h0);

    count_val = 24'd100; sr_mass_val = 24'd5; com_mass_val = 24'd50;
    run_conv(1, 10, 24'd999, -10, edges, pulses);
    check("t4_snapshot", count_bcd, 32'h00000100);

    count_val = 24'd4242; sr_mass_val = 24'd77; com_mass_val = 24'd909;
    run_conv(5, -1, '0, 30, edges, pulses);
    check("t5_pulses", pulses, 1);
    check("t5_latency", edges, LAT);
    check("t5_count", count_bcd, 32'h00004242);

    count_val = 24'd31337; sr_mass_val = 24'd1; com_mass_val = 24'd2;
    @(negedge clk);
    clk_x = 11'd0; clk_y = 10'd480;
    @(negedge clk);
    clk_x = 11'd5;
    repeat (33) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_async_count", count_bcd, 32'h0);
    check("t6_async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    run_conv(1, -1, '0, -10, edges, pulses);
    check("t6_latency", edges, LAT);
    check("t6_count", count_bcd, 32'h00031337);

    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        count_val = 24'($urandom); sr_mass_val = 24'($urandom); com_mass_val = 24'($urandom);
      end else begin
        count_val = 24'($urandom_range(0, 9999));
        sr_mass_val = 24'($urandom_range(0, 99));
        com_mass_val = 24'($urandom_range(0, 999999));
      end
      run_conv($urandom_range(1, 4), $urandom_range(5, 60), 24'($urandom), -10, edges, pulses);
      check("rand_pulses", pulses, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
